config_chain_loader: RTL



---
 rtl/config_chain_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/config_chain_loader.sv
// config_chain_loader: writer end of the tile configuration shift chain; clears the chain, then serialises CHAIN_LENGTH bits.
// Optional CRC-16-CCITT check of the shifted bitstream is enabled with CONFIG_LOADER_CRC_EN.
module config_chain_loader #(
  parameter int CHAIN_LENGTH = 24,
  parameter int WORD_WIDTH   = 8,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  config_nreset
`ifdef CONFIG_LOADER_CRC_EN
  , output logic                crc_error
`endif
);
  localparam int NWORDS = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam int WW = $clog2(NWORDS + 1);
  localparam int SW = $clog2(WORD_WIDTH + 1);
  localparam int KW = CLEAR_CYCLES > 1 ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LENGTH);
  localparam logic [WW-1:0] NW_L = WW'(NWORDS);
  localparam logic [SW-1:0] W_M1 = SW'(WORD_WIDTH - 1);
  localparam logic [KW-1:0] KMAX = KW'(CLEAR_CYCLES - 1);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, SHIFT = 3'd2, CHECK = 3'd3, DONE = 3'd4;
`ifdef CONFIG_LOADER_CRC_EN
  localparam logic [2:0] AFTER_SHIFT = CHECK;
  localparam int CRC_NW = (16 + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CRC_BITS = CRC_NW * WORD_WIDTH;
  localparam int QW = $clog2(CRC_NW + 1);
  localparam logic [QW-1:0] CRC_LAST = QW'(CRC_NW);
  logic [15:0] crc, crc_n;
  logic [CRC_BITS-1:0] acc, acc_n;
  logic [QW-1:0] ccnt, ccnt_n;
  logic err_n;
`else
  localparam logic [2:0] AFTER_SHIFT = DONE;
`endif
  logic [2:0] state, state_n;
  logic [KW-1:0] clr_cnt, clr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WW-1:0] words, words_n;
  logic [WORD_WIDTH-1:0] sr, sr_n, hold, hold_n;
  logic [SW-1:0] sr_cnt, sr_cnt_n;
  logic hold_full, hold_full_n, take, avail, bit_val, out_n, nrst_n, rdy_n;
  always_comb begin
    state_n = state;
    clr_n = clr_cnt;
    cnt_n = cnt;
    words_n = words;
    sr_n = sr;
    sr_cnt_n = sr_cnt;
    hold_n = hold;
    hold_full_n = hold_full;
    nrst_n = config_nreset;
    take = data_valid && data_ready;
    avail = 1'b0;
    bit_val = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
    crc_n = crc;
    acc_n = acc;
    ccnt_n = ccnt;
    err_n = crc_error;
`endif
    case (state)
      IDLE, DONE: if (start) begin
        state_n = CLEAR;
        clr_n = '0;
        nrst_n = 1'b0;
        cnt_n = '0;
        words_n = '0;
        sr_cnt_n = '0;
        hold_full_n = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
        crc_n = 16'hFFFF;
        ccnt_n = '0;
        err_n = 1'b0;
`endif
      end
      CLEAR: if (clr_cnt == KMAX) begin
        state_n = SHIFT;
        nrst_n = 1'b1;
      end else clr_n = clr_cnt + KW'(1);
      SHIFT: if (cnt == LAST) state_n = AFTER_SHIFT;
      else begin
        // bit source priority: shift register, then holding buffer, then the word arriving now
        if (sr_cnt != '0) begin
          bit_val = sr[WORD_WIDTH-1];
          sr_n = sr << 1;
          sr_cnt_n = sr_cnt - SW'(1);
          avail = 1'b1;
        end else if (hold_full) begin
          bit_val = hold[WORD_WIDTH-1];
          sr_n = hold << 1;
          sr_cnt_n = W_M1;
          hold_full_n = 1'b0;
          avail = 1'b1;
        end else if (take) begin
          bit_val = data_in[WORD_WIDTH-1];
          sr_n = data_in << 1;
          sr_cnt_n = W_M1;
          avail = 1'b1;
        end
        if (take && sr_cnt != '0) begin
          hold_n = data_in;
          hold_full_n = 1'b1;
        end
        words_n = words + WW'(take);
        cnt_n = cnt + CW'(avail);
      end
`ifdef CONFIG_LOADER_CRC_EN
      CHECK: if (take) begin
        acc_n = CRC_BITS'({acc, data_in});
        ccnt_n = ccnt + QW'(1);
        if (ccnt_n == CRC_LAST) begin
          state_n = DONE;
          err_n = acc_n[CRC_BITS-1 -: 16] != crc;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    out_n = avail ? bit_val : config_out;
    rdy_n = state_n == SHIFT && !hold_full_n && words_n != NW_L;
`ifdef CONFIG_LOADER_CRC_EN
    rdy_n = rdy_n || (state_n == CHECK && ccnt_n != CRC_LAST);
    if (avail) crc_n = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_val) ? 16'h1021 : 16'h0000);
`endif
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      clr_cnt <= '0;
      cnt <= '0;
      words <= '0;
      sr <= '0;
      sr_cnt <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      data_ready <= 1'b0;
      config_out <= 1'b0;
      config_enable <= 1'b0;
      config_nreset <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
      crc <= 16'hFFFF;
      acc <= '0;
      ccnt <= '0;
      crc_error <= 1'b0;
`endif
    end else begin
      state <= state_n;
      clr_cnt <= clr_n;
      cnt <= cnt_n;
      words <= words_n;
      sr <= sr_n;
      sr_cnt <= sr_cnt_n;
      hold <= hold_n;
      hold_full <= hold_full_n;
      busy <= state_n == CLEAR || state_n == SHIFT || state_n == CHECK;
      done <= state_n == DONE;
      data_ready <= rdy_n;
      config_out <= out_n;
      config_enable <= avail;
      config_nreset <= nrst_n;
`ifdef CONFIG_LOADER_CRC_EN
      crc <= crc_n;
      acc <= acc_n;
      ccnt <= ccnt_n;
      crc_error <= err_n;
`endif
    end
  end
endmodule
